cmos_capture_ctrl: RTL and testbench



---
 rtl/cmos_capture_ctrl_pkg.sv | 23 ++
 rtl/cmos_capture_ctrl_if.sv | 34 +++
 rtl/cmos_capture_ctrl_timing_chk.sv | 75 +++++++
 rtl/cmos_capture_ctrl.sv | 144 ++++++++++++++
 tb/tb_cmos_capture_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmos_capture_ctrl_pkg.sv
// Shared state encoding, default geometry and helpers for the OV5640 DVP capture sequencer.
package cmos_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SKIP    = 3'd1,
        ARMED   = 3'd2,
        CAPTURE = 3'd3
    } cap_state_t;

    localparam int DEF_H_PIXELS    = 1280;
    localparam int DEF_V_LINES     = 720;
    localparam int DEF_SKIP_FRAMES = 10;
    localparam int DEF_CNT_W       = 12;
    localparam int FRAME_CNT_W     = 16;
    localparam int SKIP_CNT_W      = 16;

    // RGB565 arrives as two bytes per pixel on the 8-bit DVP bus.
    function automatic int exp_line_bytes(input int h_pixels);
        return 2 * h_pixels;
    endfunction

endpackage

// File: rtl/cmos_capture_ctrl_if.sv
// Control/status and sensor-side signal bundle of the capture sequencer.
interface cmos_capture_ctrl_if import cmos_ctrl_pkg::*; #(
    parameter int CNT_W = DEF_CNT_W
);
    logic                   cfg_done_i;
    logic                   cap_start_i;
    logic                   cap_stop_i;
    logic                   single_shot_i;
    logic                   err_clr_i;
    logic                   vs_i;
    logic                   de_i;
    logic                   cap_de_o;
    logic                   cap_vs_o;
    logic                   sof_o;
    logic                   eof_o;
    logic [FRAME_CNT_W-1:0] frame_cnt_o;
    logic [CNT_W-1:0]       line_cnt_o;
    logic                   err_len_o;
    logic                   err_lines_o;
    logic                   busy_o;
    logic [2:0]             state_o;

    modport master (
        output cfg_done_i, cap_start_i, cap_stop_i, single_shot_i, err_clr_i, vs_i, de_i,
        input  cap_de_o, cap_vs_o, sof_o, eof_o, frame_cnt_o, line_cnt_o,
               err_len_o, err_lines_o, busy_o, state_o
    );

    modport slave (
        input  cfg_done_i, cap_start_i, cap_stop_i, single_shot_i, err_clr_i, vs_i, de_i,
        output cap_de_o, cap_vs_o, sof_o, eof_o, frame_cnt_o, line_cnt_o,
               err_len_o, err_lines_o, busy_o, state_o
    );
endinterface

// File: rtl/cmos_capture_ctrl_timing_chk.sv
// Byte/line geometry checker: admits only whole lines started while capturing and flags bad lengths.
module cmos_timing_chk import cmos_ctrl_pkg::*; #(
    parameter int H_PIXELS = DEF_H_PIXELS,
    parameter int V_LINES  = DEF_V_LINES,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             de_i,
    input  logic             cap_en_i,
    input  logic             frame_end_i,
    input  logic             err_clr_i,
    output logic             cap_de_o,
    output logic [CNT_W-1:0] line_cnt_o,
    output logic             err_len_o,
    output logic             err_lines_o
);
    localparam logic [CNT_W:0]   EXP_BYTES = (CNT_W+1)'(exp_line_bytes(H_PIXELS));
    localparam logic [CNT_W-1:0] EXP_LINES = CNT_W'(V_LINES);

    logic             r_de;
    logic             r_cap_de;
    logic [CNT_W:0]   r_byte_cnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic             r_err_len;
    logic             r_err_lines;

    logic w_de_rise;
    logic w_de_fall;
    logic w_gate;
    logic w_line_end;
    logic w_len_bad;
    logic w_lines_bad;

    // A byte passes only if its line began inside capture; the previous gate doubles as the line-admitted flag.
    assign w_de_rise   = de_i & ~r_de;
    assign w_de_fall   = ~de_i & r_de;
    assign w_gate      = de_i & cap_en_i & (w_de_rise | r_cap_de);
    assign w_line_end  = w_de_fall & r_cap_de;
    assign w_len_bad   = w_line_end & (r_byte_cnt != EXP_BYTES);
    assign w_lines_bad = frame_end_i & (r_line_cnt != EXP_LINES);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_de        <= 1'b0;
            r_cap_de    <= 1'b0;
            r_byte_cnt  <= '0;
            r_line_cnt  <= '0;
            r_err_len   <= 1'b0;
            r_err_lines <= 1'b0;
        end else begin
            r_de     <= de_i;
            r_cap_de <= w_gate;

            if (!cap_en_i || w_line_end)
                r_byte_cnt <= '0;
            else if (w_gate && !(&r_byte_cnt))
                r_byte_cnt <= r_byte_cnt + 1'b1;

            if (!cap_en_i || frame_end_i)
                r_line_cnt <= '0;
            else if (w_line_end && !(&r_line_cnt))
                r_line_cnt <= r_line_cnt + 1'b1;

            // A new error in the same cycle as a clear must survive.
            r_err_len   <= (r_err_len & ~err_clr_i) | w_len_bad;
            r_err_lines <= (r_err_lines & ~err_clr_i) | w_lines_bad;
        end
    end

    assign cap_de_o    = r_cap_de;
    assign line_cnt_o  = r_line_cnt;
    assign err_len_o   = r_err_len;
    assign err_lines_o = r_err_lines;
endmodule

// File: rtl/cmos_capture_ctrl.sv
// Frame-level capture sequencer: skips warm-up frames, then admits whole frames to the RGB565 packer.
module cmos_capture_ctrl import cmos_ctrl_pkg::*; #(
    parameter int H_PIXELS    = DEF_H_PIXELS,
    parameter int V_LINES     = DEF_V_LINES,
    parameter int SKIP_FRAMES = DEF_SKIP_FRAMES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic                pclk,
    input logic                rst_n,
    cmos_capture_ctrl_if.slave bus
);
    cap_state_t             r_state;
    cap_state_t             w_state_nxt;
    logic                   r_vs;
    logic                   r_stop_pend;
    logic                   r_sof;
    logic                   r_eof;
    logic                   r_cap_vs;
    logic                   r_busy;
    logic [SKIP_CNT_W-1:0]  r_skip_cnt;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic             w_vs_rise;
    logic             w_last_skip;
    logic             w_enter;
    logic             w_frame_end;
    logic             w_sof;
    logic             w_cap_en;
    logic             w_cap_de;
    logic [CNT_W-1:0] w_line_cnt;
    logic             w_err_len;
    logic             w_err_lines;

    assign w_vs_rise   = bus.vs_i & ~r_vs;
    assign w_last_skip = (r_skip_cnt == SKIP_CNT_W'(SKIP_FRAMES - 1));

    // Loss of sensor configuration overrides every other transition and suppresses the frame-end strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_frame_end = 1'b0;
        w_sof       = 1'b0;
        if (!bus.cfg_done_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.cap_start_i && !bus.cap_stop_i) begin
                        w_enter     = 1'b1;
                        w_state_nxt = (SKIP_FRAMES == 0) ? ARMED : SKIP;
                    end
                end
                SKIP: begin
                    if (bus.cap_stop_i)
                        w_state_nxt = IDLE;
                    else if (w_vs_rise && w_last_skip)
                        w_state_nxt = ARMED;
                end
                ARMED: begin
                    if (bus.cap_stop_i) begin
                        w_state_nxt = IDLE;
                    end else if (w_vs_rise) begin
                        w_state_nxt = CAPTURE;
                        w_sof       = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (w_vs_rise) begin
                        w_frame_end = 1'b1;
                        if (r_stop_pend || bus.cap_stop_i || bus.single_shot_i)
                            w_state_nxt = IDLE;
                        else
                            w_sof = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Gating follows the state being entered so outputs drop on the same edge as a forced return to IDLE.
    assign w_cap_en = (w_state_nxt == CAPTURE);

    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vs        <= 1'b0;
            r_stop_pend <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_cap_vs    <= 1'b0;
            r_busy      <= 1'b0;
            r_skip_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_vs     <= bus.vs_i;
            r_sof    <= w_sof;
            r_eof    <= w_frame_end;
            r_cap_vs <= bus.vs_i & ((w_state_nxt == ARMED) || (w_state_nxt == CAPTURE));
            r_busy   <= (w_state_nxt != IDLE);
            if (w_enter) begin
                r_skip_cnt  <= '0;
                r_stop_pend <= 1'b0;
                r_frame_cnt <= '0;
            end else begin
                if (r_state == SKIP && w_vs_rise)
                    r_skip_cnt <= r_skip_cnt + 1'b1;
                if (r_state == CAPTURE && bus.cap_stop_i)
                    r_stop_pend <= 1'b1;
                if (w_frame_end)
                    r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    cmos_timing_chk #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES),
        .CNT_W    (CNT_W)
    ) u_timing_chk (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .de_i        (bus.de_i),
        .cap_en_i    (w_cap_en),
        .frame_end_i (w_frame_end),
        .err_clr_i   (bus.err_clr_i),
        .cap_de_o    (w_cap_de),
        .line_cnt_o  (w_line_cnt),
        .err_len_o   (w_err_len),
        .err_lines_o (w_err_lines)
    );

    assign bus.cap_de_o    = w_cap_de;
    assign bus.cap_vs_o    = r_cap_vs;
    assign bus.sof_o       = r_sof;
    assign bus.eof_o       = r_eof;
    assign bus.frame_cnt_o = r_frame_cnt;
    assign bus.line_cnt_o  = w_line_cnt;
    assign bus.err_len_o   = w_err_len;
    assign bus.err_lines_o = w_err_lines;
    assign bus.busy_o      = r_busy;
    assign bus.state_o     = r_state;
endmodule

// File: tb/tb_cmos_capture_ctrl.sv
// Randomized bench for cmos_capture_ctrl; expectations come from a frame/line-level model of the sequencer.
module tb_cmos_capture_ctrl;
    localparam int H          = 4;
    localparam int V          = 3;
    localparam int SKIP       = 2;
    localparam int CW         = 12;
    localparam int LINE_BYTES = 2 * H;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SKIP    = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    cmos_capture_ctrl_if #(.CNT_W(CW)) cif ();

    cmos_capture_ctrl #(
        .H_PIXELS    (H),
        .V_LINES     (V),
        .SKIP_FRAMES (SKIP),
        .CNT_W       (CW)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .bus   (cif)
    );

    always #5 pclk = ~pclk;

    int errors    = 0;
    int checks    = 0;
    int sofCnt    = 0;
    int eofCnt    = 0;
    int deCnt     = 0;
    int expFrames = 0;

    // Pulse/byte monitor sampling shortly after each active edge.
    always begin
        @(posedge pclk);
        #2;
        if (cif.sof_o === 1'b1) sofCnt++;
        if (cif.eof_o === 1'b1) eofCnt++;
        if (cif.cap_de_o === 1'b1) deCnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic send_line(input int nBytes, input bit clrAtEnd);
        cif.de_i = 1'b1;
        tick(nBytes);
        cif.de_i      = 1'b0;
        cif.err_clr_i = clrAtEnd;
        tick(1);
        cif.err_clr_i = 1'b0;
        tick($urandom_range(1, 3));
    endtask

    task automatic send_lines(input int n);
        repeat (n) send_line(LINE_BYTES, 1'b0);
    endtask

    task automatic send_vs(output logic capVs);
        cif.vs_i = 1'b1;
        tick(1);
        capVs = cif.cap_vs_o;
        tick(1);
        cif.vs_i = 1'b0;
        tick(2);
    endtask

    task automatic pulse_start();
        cif.cap_start_i = 1'b1;
        tick(1);
        cif.cap_start_i = 1'b0;
    endtask

    task automatic skip_frames();
        logic v;
        repeat (SKIP) begin
            send_vs(v);
            send_lines(V);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cif.cfg_done_i = 1'b1; cif.cap_start_i = 1'b1; cif.vs_i = 1'b1; cif.de_i = 1'b1;
        tick(3);
        checks++; if (cif.state_o !== S_IDLE || cif.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_state: got %0d/%0d expected 0/0", cif.state_o, cif.busy_o); end
        checks++; if ({cif.sof_o, cif.eof_o, cif.cap_de_o, cif.cap_vs_o} !== 4'b0) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {cif.sof_o, cif.eof_o, cif.cap_de_o, cif.cap_vs_o}); end
        checks++; if (cif.frame_cnt_o !== 16'd0 || cif.line_cnt_o !== '0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cif.frame_cnt_o, cif.line_cnt_o); end
        checks++; if ({cif.err_len_o, cif.err_lines_o} !== 2'b00) begin errors++; $display("[TB] FAIL reset_errors: got %b expected 00", {cif.err_len_o, cif.err_lines_o}); end
        cif.cfg_done_i = 1'b0; cif.cap_start_i = 1'b0; cif.vs_i = 1'b0; cif.de_i = 1'b0;
        rst_n = 1'b1;
        tick(2);
        checks++; if (cif.state_o !== S_IDLE) begin errors++; $display("[TB] FAIL post_reset_idle: got %0d expected 0", cif.state_o); end
    endtask

    task automatic test_normal();
        logic v;
        int de0, sof0, eof0, nExtra;
        cif.cfg_done_i = 1'b1;
        tick(2);
        pulse_start();
        checks++; if ({cif.state_o, cif.busy_o} !== {S_SKIP, 1'b1}) begin errors++; $display("[TB] FAIL start_to_skip: got %0d/%0d expected 1/1", cif.state_o, cif.busy_o); end
        de0  = deCnt;
        sof0 = sofCnt;
        send_vs(v);
        checks++; if (v !== 1'b0) begin errors++; $display("[TB] FAIL skip_vs_gated: got %b expected 0", v); end
        send_lines(V);
        send_vs(v);
        send_lines(V);
        checks++; if (cif.state_o !== S_ARMED) begin errors++; $display("[TB] FAIL armed_after_skip: got %0d expected 2", cif.state_o); end
        checks++; if (deCnt !== de0 || sofCnt !== sof0) begin errors++; $display("[TB] FAIL skip_no_output: got de=%0d sof=%0d expected de=%0d sof=%0d", deCnt, sofCnt, de0, sof0); end
        send_vs(v);
        checks++; if (sofCnt !== sof0 + 1 || cif.state_o !== S_CAPTURE) begin errors++; $display("[TB] FAIL first_sof: got sof=%0d state=%0d expected sof=%0d state=3", sofCnt, cif.state_o, sof0 + 1); end
        checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL capture_vs_pass: got %b expected 1", v); end
        eof0 = eofCnt;
        send_lines(V);
        checks++; if (deCnt - de0 !== V * LINE_BYTES) begin errors++; $display("[TB] FAIL frame1_bytes: got %0d expected %0d", deCnt - de0, V * LINE_BYTES); end
        checks++; if (cif.line_cnt_o !== CW'(V)) begin errors++; $display("[TB] FAIL frame1_lines: got %0d expected %0d", cif.line_cnt_o, V); end
        send_vs(v);
        expFrames = 1;
        checks++; if (eofCnt !== eof0 + 1 || sofCnt !== sof0 + 2) begin errors++; $display("[TB] FAIL frame1_eof_sof: got eof=%0d sof=%0d expected eof=%0d sof=%0d", eofCnt, sofCnt, eof0 + 1, sof0 + 2); end
        checks++; if (cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL frame1_count: got %0d expected %0d", cif.frame_cnt_o, expFrames); end
        checks++; if ({cif.err_len_o, cif.err_lines_o, cif.state_o} !== {2'b00, S_CAPTURE}) begin errors++; $display("[TB] FAIL frame1_clean: got err=%b state=%0d expected err=00 state=3", {cif.err_len_o, cif.err_lines_o}, cif.state_o); end
        checks++; if (cif.line_cnt_o !== '0) begin errors++; $display("[TB] FAIL frame1_line_clear: got %0d expected 0", cif.line_cnt_o); end
        nExtra = $urandom_range(1, 3);
        repeat (nExtra) begin
            send_lines(V);
            send_vs(v);
            expFrames++;
        end
        checks++; if (cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL multi_frame_count: got %0d expected %0d", cif.frame_cnt_o, expFrames); end
        checks++; if (deCnt - de0 !== expFrames * V * LINE_BYTES) begin errors++; $display("[TB] FAIL multi_frame_bytes: got %0d expected %0d", deCnt - de0, expFrames * V * LINE_BYTES); end
    endtask

    task automatic test_start_ignored();
        logic v;
        send_line(LINE_BYTES, 1'b0);
        pulse_start();
        checks++; if (cif.frame_cnt_o !== 16'(expFrames) || cif.state_o !== S_CAPTURE) begin errors++; $display("[TB] FAIL start_busy_ignored: got cnt=%0d state=%0d expected cnt=%0d state=3", cif.frame_cnt_o, cif.state_o, expFrames); end
        send_lines(V - 1);
        send_vs(v);
        expFrames++;
        checks++; if (cif.frame_cnt_o !== 16'(expFrames) || cif.err_lines_o !== 1'b0) begin errors++; $display("[TB] FAIL start_busy_frame: got cnt=%0d errl=%b expected cnt=%0d errl=0", cif.frame_cnt_o, cif.err_lines_o, expFrames); end
    endtask

    task automatic test_bad_geometry();
        logic v;
        int bad, nLines;
        bad    = ($urandom_range(0, 1) == 0) ? $urandom_range(1, LINE_BYTES - 1) : $urandom_range(LINE_BYTES + 1, LINE_BYTES + 4);
        nLines = ($urandom_range(0, 1) == 0) ? V - 1 : V + 1;
        send_line(LINE_BYTES, 1'b0);
        checks++; if (cif.err_len_o !== 1'b0) begin errors++; $display("[TB] FAIL good_line_no_err: got %b expected 0", cif.err_len_o); end
        send_line(bad, 1'b0);
        checks++; if (cif.err_len_o !== 1'b1) begin errors++; $display("[TB] FAIL bad_line_err (%0d bytes): got %b expected 1", bad, cif.err_len_o); end
        send_line(LINE_BYTES, 1'b0);
        send_vs(v);
        expFrames++;
        checks++; if (cif.err_lines_o !== 1'b0 || cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL full_frame_lines: got errl=%b cnt=%0d expected errl=0 cnt=%0d", cif.err_lines_o, cif.frame_cnt_o, expFrames); end
        cif.err_clr_i = 1'b1;
        tick(1);
        cif.err_clr_i = 1'b0;
        checks++; if (cif.err_len_o !== 1'b0) begin errors++; $display("[TB] FAIL err_len_clear: got %b expected 0", cif.err_len_o); end
        send_lines(nLines);
        send_vs(v);
        expFrames++;
        checks++; if ({cif.err_lines_o, cif.err_len_o} !== 2'b10) begin errors++; $display("[TB] FAIL short_long_frame (%0d lines): got errl/errb=%b expected 10", nLines, {cif.err_lines_o, cif.err_len_o}); end
        send_line(bad, 1'b1);
        checks++; if ({cif.err_len_o, cif.err_lines_o} !== 2'b10) begin errors++; $display("[TB] FAIL set_beats_clear: got errb/errl=%b expected 10", {cif.err_len_o, cif.err_lines_o}); end
        send_lines(V - 1);
        send_vs(v);
        expFrames++;
        checks++; if (cif.err_lines_o !== 1'b0 || cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL frame_after_clear: got errl=%b cnt=%0d expected errl=0 cnt=%0d", cif.err_lines_o, cif.frame_cnt_o, expFrames); end
        cif.err_clr_i = 1'b1;
        tick(1);
        cif.err_clr_i = 1'b0;
        checks++; if ({cif.err_len_o, cif.err_lines_o} !== 2'b00) begin errors++; $display("[TB] FAIL final_clear: got %b expected 00", {cif.err_len_o, cif.err_lines_o}); end
    endtask

    task automatic test_stop();
        logic v;
        int sof0, eof0;
        sof0 = sofCnt;
        eof0 = eofCnt;
        send_line(LINE_BYTES, 1'b0);
        cif.cap_stop_i = 1'b1;
        tick(1);
        cif.cap_stop_i = 1'b0;
        checks++; if (cif.state_o !== S_CAPTURE) begin errors++; $display("[TB] FAIL stop_frame_continues: got %0d expected 3", cif.state_o); end
        send_lines(V - 1);
        send_vs(v);
        expFrames++;
        checks++; if (eofCnt !== eof0 + 1 || sofCnt !== sof0) begin errors++; $display("[TB] FAIL stop_last_eof: got eof=%0d sof=%0d expected eof=%0d sof=%0d", eofCnt, sofCnt, eof0 + 1, sof0); end
        checks++; if (cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL stop_frame_count: got %0d expected %0d", cif.frame_cnt_o, expFrames); end
        checks++; if ({cif.state_o, cif.busy_o} !== {S_IDLE, 1'b0}) begin errors++; $display("[TB] FAIL stop_idle: got %0d/%0d expected 0/0", cif.state_o, cif.busy_o); end
        pulse_start();
        checks++; if (cif.state_o !== S_SKIP || cif.frame_cnt_o !== 16'd0) begin errors++; $display("[TB] FAIL restart_clears: got state=%0d cnt=%0d expected state=1 cnt=0", cif.state_o, cif.frame_cnt_o); end
        tick(2);
        cif.cap_stop_i = 1'b1;
        tick(1);
        cif.cap_stop_i = 1'b0;
        checks++; if ({cif.state_o, cif.busy_o} !== {S_IDLE, 1'b0}) begin errors++; $display("[TB] FAIL stop_in_skip: got %0d/%0d expected 0/0", cif.state_o, cif.busy_o); end
    endtask

    task automatic test_partial_line();
        logic v;
        int de0, sof0;
        pulse_start();
        skip_frames();
        checks++; if (cif.state_o !== S_ARMED) begin errors++; $display("[TB] FAIL partial_armed: got %0d expected 2", cif.state_o); end
        de0  = deCnt;
        sof0 = sofCnt;
        cif.de_i = 1'b1;
        tick($urandom_range(2, 4));
        cif.vs_i = 1'b1;
        tick(1);
        checks++; if (cif.state_o !== S_CAPTURE || sofCnt !== sof0 + 1) begin errors++; $display("[TB] FAIL partial_sof: got state=%0d sof=%0d expected state=3 sof=%0d", cif.state_o, sofCnt, sof0 + 1); end
        tick(1);
        cif.vs_i = 1'b0;
        tick(3);
        cif.de_i = 1'b0;
        tick(2);
        checks++; if (deCnt !== de0) begin errors++; $display("[TB] FAIL partial_masked: got %0d bytes expected 0", deCnt - de0); end
        send_lines(V);
        checks++; if (deCnt - de0 !== V * LINE_BYTES || cif.line_cnt_o !== CW'(V)) begin errors++; $display("[TB] FAIL after_partial: got bytes=%0d lines=%0d expected bytes=%0d lines=%0d", deCnt - de0, cif.line_cnt_o, V * LINE_BYTES, V); end
        send_vs(v);
        expFrames = 1;
        checks++; if (cif.frame_cnt_o !== 16'(expFrames) || {cif.err_len_o, cif.err_lines_o} !== 2'b00) begin errors++; $display("[TB] FAIL partial_frame_end: got cnt=%0d err=%b expected cnt=%0d err=00", cif.frame_cnt_o, {cif.err_len_o, cif.err_lines_o}, expFrames); end
    endtask

    task automatic test_cfg_loss();
        int eof0;
        eof0 = eofCnt;
        send_line(LINE_BYTES, 1'b0);
        cif.de_i = 1'b1;
        tick(2);
        checks++; if (cif.cap_de_o !== 1'b1) begin errors++; $display("[TB] FAIL cfg_pre_de: got %b expected 1", cif.cap_de_o); end
        cif.cfg_done_i = 1'b0;
        tick(1);
        checks++; if ({cif.state_o, cif.busy_o} !== {S_IDLE, 1'b0}) begin errors++; $display("[TB] FAIL cfg_loss_idle: got %0d/%0d expected 0/0", cif.state_o, cif.busy_o); end
        checks++; if ({cif.cap_de_o, cif.cap_vs_o} !== 2'b00) begin errors++; $display("[TB] FAIL cfg_loss_gate: got %b expected 00", {cif.cap_de_o, cif.cap_vs_o}); end
        cif.de_i = 1'b0;
        tick(3);
        checks++; if (eofCnt !== eof0 || cif.frame_cnt_o !== 16'(expFrames)) begin errors++; $display("[TB] FAIL cfg_loss_no_eof: got eof=%0d cnt=%0d expected eof=%0d cnt=%0d", eofCnt, cif.frame_cnt_o, eof0, expFrames); end
        cif.cfg_done_i = 1'b1;
        tick(1);
    endtask

    task automatic test_single_shot();
        logic v;
        int sof0, eof0, de0;
        cif.single_shot_i = 1'b1;
        pulse_start();
        skip_frames();
        sof0 = sofCnt;
        eof0 = eofCnt;
        send_vs(v);
        send_lines(V);
        send_vs(v);
        checks++; if (sofCnt !== sof0 + 1 || eofCnt !== eof0 + 1) begin errors++; $display("[TB] FAIL single_pair: got sof=%0d eof=%0d expected sof=%0d eof=%0d", sofCnt - sof0, eofCnt - eof0, 1, 1); end
        checks++; if (cif.frame_cnt_o !== 16'd1 || cif.state_o !== S_IDLE) begin errors++; $display("[TB] FAIL single_done: got cnt=%0d state=%0d expected cnt=1 state=0", cif.frame_cnt_o, cif.state_o); end
        de0 = deCnt;
        send_vs(v);
        send_lines(1);
        checks++; if (sofCnt !== sof0 + 1 || deCnt !== de0) begin errors++; $display("[TB] FAIL single_no_more: got sof=%0d bytes=%0d expected sof=1 bytes=0", sofCnt - sof0, deCnt - de0); end
        cif.single_shot_i = 1'b0;
    endtask

    initial begin
        cif.cfg_done_i    = 1'b0;
        cif.cap_start_i   = 1'b0;
        cif.cap_stop_i    = 1'b0;
        cif.single_shot_i = 1'b0;
        cif.err_clr_i     = 1'b0;
        cif.vs_i          = 1'b0;
        cif.de_i          = 1'b0;
        test_reset();
        test_normal();
        test_start_ignored();
        test_bad_geometry();
        test_stop();
        test_partial_line();
        test_cfg_loss();
        test_single_shot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
